// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions: opcode constants, reset PC, FSM encoding
// and the fetch buffer entry layout.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          FETCH_BUF_DEPTH  = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Sequential fetch address; wraps 32'hFFFF_FFFC to 0 through natural overflow.
   function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode,
// with a synchronous flush that wins over push and pop.
module fetch_buffer
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_pc,
   input  logic [31:0] push_instr,
   output logic        head_valid,
   output logic [31:0] head_pc,
   output logic [31:0] head_instr,
   output logic [1:0]  count
);

   fetch_entry_t entries [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop  && (count != 2'd0);
   assign do_push = push && (count != 2'd2);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage is deliberately not reset; count alone qualifies it.
   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= '{pc: push_pc, instr: push_instr};
   end

   assign head_valid = (count != 2'd0);
   assign head_pc    = entries[rd_ptr].pc;
   assign head_instr = entries[rd_ptr].instr;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: IDLE/FETCH/DRAIN sequencing, PC generation and branch
// redirect in front of a two-entry fetch buffer feeding decode.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [31:0] pc_out,
   input  logic        instr_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        misalign_err
);

   localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

   logic [1:0]  state;
   logic [31:0] fetch_pc;
   logic [31:0] drain_addr;
   logic [1:0]  buf_count;
   logic        buf_valid;
   logic [31:0] head_pc;
   logic [31:0] head_instr;
   logic        pop;
   logic        redirect;
   logic        handshake;
   logic        push;

   assign instr_valid = buf_valid;
   assign pop         = instr_valid && instr_ready;
   assign redirect    = pop && branch_taken;
   assign handshake   = imem_req && imem_ready;
   assign push        = handshake && (state == ST_FETCH) && !redirect;

   // NOTE: every output of this block gets a default first, so no path
   // through the case can infer a latch.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fetch_pc;
      case (state)
         ST_FETCH: imem_req = (buf_count < DEPTH);
         ST_DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drain_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         fetch_pc     <= RESET_PC;
         drain_addr   <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= redirect && (branch_target[1:0] != 2'b00);
         case (state)
            ST_IDLE: state <= ST_FETCH;
            ST_FETCH: begin
               if (redirect) begin
                  fetch_pc <= word_align(branch_target);
                  // An unanswered request must still be completed, then dropped.
                  if (imem_req && !imem_ready) begin
                     state      <= ST_DRAIN;
                     drain_addr <= fetch_pc;
                  end
               end else if (push) begin
                  fetch_pc <= next_fetch_pc(fetch_pc);
               end
            end
            ST_DRAIN: if (imem_ready) state <= ST_FETCH;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   fetch_buffer u_buffer (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .push       (push),
      .pop        (pop),
      .push_pc    (fetch_pc),
      .push_instr (imem_rdata),
      .head_valid (buf_valid),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (buf_count)
   );

   assign instr  = instr_valid ? head_instr : 32'h0;
   assign pc_out = instr_valid ? head_pc    : 32'h0;
   assign opcode = instr[6:0];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: BUF_DEPTH, 2, fetched-instruction buffer entries; fixed at 2 for this release.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_ready  input  1  memory response; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  head buffer entry valid toward decode.
REQ-011 instr  output  32  head instruction; 0 when instr_valid=0.
REQ-012 opcode  output  7  instr[6:0]; feeds the control unit.
REQ-013 pc_out  output  32  address of head instruction; 0 when instr_valid=0.
REQ-014 instr_ready  input  1  decode accepts head entry (pop).
REQ-015 branch_taken  input  1  redirect request (Branch AND Zero from the datapath).
REQ-016 branch_target  input  32  redirect address.
REQ-017 misalign_err  output  1  one-cycle pulse: accepted redirect had branch_target[1:0]!=0.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, and DRAIN; IDLE lasts exactly one cycle after rst deasserts, then the FSM moves to FETCH.
REQ-019 In FETCH, imem_req SHALL be 1 iff the registered buffer count < 2; imem_addr SHALL equal fetch_pc.
REQ-020 Once asserted, imem_req and imem_addr SHALL hold stable until a cycle with imem_ready=1; at most one request is outstanding.
REQ-021 On imem_req&&imem_ready with no redirect, the block SHALL push {fetch_pc, imem_rdata} and set fetch_pc <= fetch_pc+4, wrapping 32'hFFFF_FFFC to 0.
REQ-022 Pop SHALL occur on instr_valid&&instr_ready; simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-023 A push into a full buffer SHALL be impossible; imem_ready while imem_req=0 SHALL be ignored.
REQ-024 branch_taken SHALL be honoured only in a cycle with instr_valid&&instr_ready; otherwise it is ignored.
REQ-025 On an honoured redirect: the buffer is flushed (count=0, the popping entry consumed); fetch_pc <= {branch_target[31:2],2'b00}; misalign_err pulses next cycle if branch_target[1:0]!=0.
REQ-026 Redirect with imem_req=1 and imem_ready=0: the FSM SHALL enter DRAIN, holding the old request until imem_ready, discarding that response, then returning to FETCH at the new fetch_pc.
REQ-027 Redirect with imem_req&&imem_ready in the same cycle: the response SHALL be discarded and the FSM stays in FETCH.
REQ-028 In DRAIN, branch_taken SHALL be ignored because instr_valid=0.
REQ-029 Latency: the first instr_valid SHALL occur at the earliest 2 cycles after rst deasserts, with zero-wait memory.

Reset
REQ-030 While rst=1: state=IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, pc_out=0, misalign_err=0.
REQ-031 rst asserted mid-handshake (including in DRAIN) SHALL drop imem_req the next cycle; any pending response is abandoned.

Structure
REQ-032 Shared package riscv_pkg SHALL hold the opcode constants (R=7'b0110011, LOAD=7'b0000011, STORE=7'b0100011, BRANCH=7'b1100011), the default RESET_PC, and the FSM state encoding.
REQ-033 The buffer SHALL be a sub-module fetch_buffer (2-entry FIFO of {pc, instr}, with flush, push, and pop); the FSM and PC logic stay in instr_fetch_unit.

Verification
REQ-034 Reset release, zero-wait memory returning 32'h00000033 at address 0 -> instr_valid at cycle 2, pc_out=0, opcode=7'b0110011, and the next imem_addr=4.
REQ-035 instr_ready=0 for 5 cycles -> 2 entries buffered (pc 0, 4), imem_req=0, addr 8 not requested until a pop occurs.
REQ-036 Redirect to 32'h100 while a request is pending with imem_ready=0 for 3 cycles -> DRAIN, stale data not delivered, next instr_valid shows pc_out=32'h100.
REQ-037 Redirect to 32'h102 -> misalign_err pulses once, fetch resumes at 32'h100.
REQ-038 fetch_pc=32'hFFFF_FFFC with no redirect -> the next imem_addr is 0.
REQ-039 rst asserted with imem_req=1 pending -> imem_req=0 the next cycle, then the fetch restarts at RESET_PC.
